wave_scheduler: RTL and testbench
=================================

WAVE_SCHEDULER -- requirements
Module: wave_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the sample/DAC code width.
REQ-002 SHALL have parameter N_SRC, default 3, meaning the number of waveform sources sharing one R2R/PWM DAC path.
REQ-003 SHALL have parameter MAX_PERIOD_CLKS, default 100_000_000, meaning the timeout bound in clocks (used only under REQ-026).
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port req, input, N_SRC bits: source i requests the DAC.
REQ-007 SHALL have port sample, input, N_SRC x WIDTH: current code of each source.
REQ-008 SHALL have port period_done, input, N_SRC bits: one-clock pulse when source i wraps its period.
REQ-009 SHALL have port src_enable, output, N_SRC bits: run enable to each source (low restarts the source from 0).
REQ-010 SHALL have port grant, output, N_SRC bits: one-hot owner, all-zero when none.
REQ-011 SHALL have port dac_out, output, WIDTH bits: the selected code, driving R2R and the PWM duty.
REQ-012 SHALL have port busy, output, 1 bit: high in RUN or DRAIN.
REQ-013 SHALL have port fault, output, 1 bit: sticky timeout flag.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN and DRAIN.
REQ-015 In IDLE, SHALL hold grant=0, src_enable=0 and dac_out=0; when any req bit is high, SHALL pick an owner round-robin and enter RUN on the next clock.
REQ-016 SHALL search round-robin starting at index (last_owner+1) mod N_SRC and wrapping, and SHALL pick the lowest index at or above that start that is requesting.
REQ-017 In RUN, SHALL set grant and src_enable to the owner's one-hot and register dac_out <= sample[owner] every clock, giving 1-clock latency.
REQ-018 In RUN, a period_done[owner] pulse with another req bit high, or with req[owner] low, SHALL move the FSM to DRAIN; otherwise the FSM SHALL stay in RUN.
REQ-019 A req[owner] deassert mid-period SHALL NOT end the grant early; the current period always completes.
REQ-020 Pulses on period_done for non-owners SHALL be ignored.
REQ-021 DRAIN SHALL last exactly 1 clock, with src_enable=0, grant=0 and dac_out=0; it then enters RUN with a new round-robin pick if any req bit is high, else IDLE.
REQ-022 last_owner SHALL update upon entry to RUN.
REQ-023 A sole continuous requester SHALL keep the grant indefinitely with no DRAIN gaps.

Reset
REQ-024 With reset low at a clk edge, SHALL enter IDLE with grant=0, src_enable=0, dac_out=0, busy=0 and fault=0, and SHALL set last_owner=N_SRC-1 so that index 0 wins first.
REQ-025 Reset asserted in any state, including mid-RUN, SHALL take effect on that edge with no drain cycle.

Configuration
REQ-026 With macro WAVE_SCHED_TIMEOUT_EN defined:
- A counter SHALL clear on RUN entry and on period_done[owner], and SHALL increment otherwise in RUN.
- On reaching MAX_PERIOD_CLKS-1, the FSM SHALL force DRAIN and set fault high until reset.
REQ-027 Without WAVE_SCHED_TIMEOUT_EN, no counter SHALL exist, fault SHALL be constant 0, and RUN SHALL exit only per REQ-018.

Structure
REQ-028 Package wave_sched_pkg SHALL hold the state enum type (IDLE, RUN, DRAIN) and the function computing counter width from MAX_PERIOD_CLKS.
REQ-029 Round-robin selection SHALL be a sub-module rr_picker (inputs req and last_owner; outputs one-hot pick and valid).

Verification
REQ-030 With N_SRC=3 and req=3'b001 held, the bench SHALL see grant=001 one clock after reset release, dac_out tracking sample[0] at 1-clock lag, and no DRAIN across 3 period_done pulses.
REQ-031 With req=3'b011 and owner 0, a period_done[0] SHALL produce 1 DRAIN clock (all outputs 0), then grant=010.
REQ-032 With owner 2 and req=3'b111, a period_done[2] SHALL produce DRAIN, then grant=001 (wrap).
REQ-033 With req[0] dropped mid-period, grant=001 SHALL hold until period_done[0], then DRAIN, then IDLE with busy=0.
REQ-034 Reset pulled low mid-RUN with grant=100 SHALL give all outputs 0 on the next edge; after release with req=111, grant SHALL be 001.
REQ-035 With WAVE_SCHED_TIMEOUT_EN and MAX_PERIOD_CLKS=16, holding period_done=0 SHALL produce DRAIN after 16 RUN clocks and fault=1 held until reset.

Source files
------------

// File: rtl/wave_sched_pkg.sv
// Shared types and sizing helpers for the wave scheduler (state encoding, index/counter widths).
package wave_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bits needed to count 0 .. max_clks-1
  function automatic int unsigned cnt_width(input int unsigned max_clks);
    return (max_clks > 2) ? $clog2(max_clks) : 1;
  endfunction

endpackage

// File: rtl/wave_scheduler_rr_picker.sv
// Round-robin picker: first requester at or after (last_owner+1) mod N_SRC, wrapping.
module rr_picker
  import wave_sched_pkg::*;
#(
  parameter int unsigned N_SRC = 3,
  parameter int unsigned IDX_W = idx_width(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] last_owner,
  output logic [N_SRC-1:0] pick,
  output logic             valid
);

  int unsigned start;
  int unsigned idx;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = 0;
    start = 32'(last_owner) + 32'd1;
    if (start >= N_SRC) start = 0;
    for (int unsigned off = 0; off < N_SRC; off++) begin
      idx = start + off;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!valid && req[IDX_W'(idx)]) begin
        pick[IDX_W'(idx)] = 1'b1;
        valid             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wave_scheduler.sv
// Time-shares one R2R/PWM DAC path among N_SRC waveform sources, one full period per grant.
// Optional per-period watchdog enabled by defining WAVE_SCHED_TIMEOUT_EN.
module wave_scheduler
  import wave_sched_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned N_SRC           = 3,
  parameter int unsigned MAX_PERIOD_CLKS = 100_000_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_SRC-1:0]            req,
  input  logic [N_SRC-1:0][WIDTH-1:0] sample,
  input  logic [N_SRC-1:0]            period_done,
  output logic [N_SRC-1:0]            src_enable,
  output logic [N_SRC-1:0]            grant,
  output logic [WIDTH-1:0]            dac_out,
  output logic                        busy,
  output logic                        fault
);

  localparam int unsigned IDX_W = idx_width(N_SRC);

  if (N_SRC < 1 || WIDTH < 1 || MAX_PERIOD_CLKS < 2) begin : g_bad_cfg
    $error("wave_scheduler: invalid parameter set");
  end

  state_t           state;
  logic [IDX_W-1:0] last_owner;
  logic [N_SRC-1:0] pick;
  logic             pick_valid;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_done_c;
  logic             leave_run_c;
  logic             enter_run_c;
  logic             timeout_c;

  rr_picker #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .req        (req),
    .last_owner (last_owner),
    .pick       (pick),
    .valid      (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  // During RUN last_owner is the current owner and grant is its one-hot
  assign owner_done_c = period_done[last_owner];
  assign leave_run_c  = owner_done_c && ((|(req & ~grant)) || !req[last_owner]);
  assign enter_run_c  = (state != RUN) && pick_valid;

`ifdef WAVE_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = cnt_width(MAX_PERIOD_CLKS);

  logic [CNT_W-1:0] period_cnt;
  logic             fault_q;

  assign timeout_c = (state == RUN) && (period_cnt == CNT_W'(MAX_PERIOD_CLKS - 1));
  assign fault     = fault_q;

  // Clocks since RUN entry or the owner's last period wrap; fault is sticky
  always_ff @(posedge clk) begin
    if (!reset) begin
      period_cnt <= '0;
      fault_q    <= 1'b0;
    end else begin
      if (enter_run_c || (state == RUN && owner_done_c)) begin
        period_cnt <= '0;
      end else if (state == RUN) begin
        period_cnt <= period_cnt + CNT_W'(1);
      end
      if (timeout_c) fault_q <= 1'b1;
    end
  end
`else
  assign timeout_c = 1'b0;
  assign fault     = 1'b0;
`endif

  // Main FSM with registered outputs; DRAIN is a single all-zero clock between owners
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      last_owner <= IDX_W'(N_SRC - 1);
      grant      <= '0;
      src_enable <= '0;
      dac_out    <= '0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DRAIN: begin
          if (pick_valid) begin
            state      <= RUN;
            last_owner <= pick_idx;
            grant      <= pick;
            src_enable <= pick;
            dac_out    <= sample[pick_idx];
            busy       <= 1'b1;
          end else begin
            state      <= IDLE;
            grant      <= '0;
            src_enable <= '0;
            dac_out    <= '0;
            busy       <= 1'b0;
          end
        end
        RUN: begin
          if (timeout_c || leave_run_c) begin
            state      <= DRAIN;
            grant      <= '0;
            src_enable <= '0;
            dac_out    <= '0;
            busy       <= 1'b1;
          end else begin
            state   <= RUN;
            dac_out <= sample[last_owner];
            busy    <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          grant      <= '0;
          src_enable <= '0;
          dac_out    <= '0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wave_scheduler.sv
// Directed bench for wave_scheduler (N_SRC=3, WIDTH=8, MAX_PERIOD_CLKS=16).
module tb_wave_scheduler;

  logic             clk;
  logic             reset;
  logic [2:0]       req;
  logic [2:0][7:0]  sample;
  logic [2:0]       period_done;
  logic [2:0]       src_enable;
  logic [2:0]       grant;
  logic [7:0]       dac_out;
  logic             busy;
  logic             fault;

  int checks = 0;
  int errors = 0;

  wave_scheduler #(
    .WIDTH           (8),
    .N_SRC           (3),
    .MAX_PERIOD_CLKS (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .sample      (sample),
    .period_done (period_done),
    .src_enable  (src_enable),
    .grant       (grant),
    .dac_out     (dac_out),
    .busy        (busy),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 3'b000; period_done = 3'b000;
    sample[0] = 8'h10; sample[1] = 8'h20; sample[2] = 8'h30;
    tick(); tick();
    checks++; if ({grant, src_enable, dac_out, busy, fault} !== 16'h0) begin errors++;
      $display("FAIL reset_outputs got g=%b e=%b d=%h b=%b f=%b want all 0", grant, src_enable, dac_out, busy, fault); end
  endtask

  task automatic test_sole_requester();
    req = 3'b001; reset = 1'b1;
    tick();
    checks++; if (grant !== 3'b001 || src_enable !== 3'b001 || busy !== 1'b1) begin errors++;
      $display("FAIL sole_first_grant got g=%b e=%b b=%b want 001 001 1", grant, src_enable, busy); end
    checks++; if (dac_out !== 8'h10) begin errors++;
      $display("FAIL sole_first_dac got %h want 10", dac_out); end
    sample[0] = 8'h11;
    tick();
    checks++; if (dac_out !== 8'h11) begin errors++;
      $display("FAIL sole_dac_lag got %h want 11", dac_out); end
    for (int k = 0; k < 3; k++) begin
      period_done = 3'b001; sample[0] = 8'(8'h40 + k);
      tick();
      period_done = 3'b000;
      checks++; if (grant !== 3'b001 || busy !== 1'b1 || dac_out !== 8'(8'h40 + k)) begin errors++;
        $display("FAIL sole_no_drain[%0d] got g=%b b=%b d=%h want 001 1 %h", k, grant, busy, dac_out, 8'(8'h40 + k)); end
      tick();
      checks++; if (grant !== 3'b001) begin errors++;
        $display("FAIL sole_hold[%0d] got %b want 001", k, grant); end
    end
    sample[0] = 8'h10;
  endtask

  task automatic test_rotate_and_wrap();
    req = 3'b011;
    tick();
    checks++; if (grant !== 3'b001) begin errors++;
      $display("FAIL rot_before got %b want 001", grant); end
    period_done = 3'b001;
    tick();
    period_done = 3'b000;
    checks++; if ({grant, src_enable, dac_out} !== 14'h0 || busy !== 1'b1) begin errors++;
      $display("FAIL rot_drain got g=%b e=%b d=%h b=%b want 0 0 0 1", grant, src_enable, dac_out, busy); end
    tick();
    checks++; if (grant !== 3'b010 || src_enable !== 3'b010 || dac_out !== 8'h20) begin errors++;
      $display("FAIL rot_next got g=%b e=%b d=%h want 010 010 20", grant, src_enable, dac_out); end
    req = 3'b111;
    period_done = 3'b010;
    tick();
    period_done = 3'b000;
    checks++; if (grant !== 3'b000) begin errors++;
      $display("FAIL wrap_drain1 got %b want 000", grant); end
    tick();
    checks++; if (grant !== 3'b100 || dac_out !== 8'h30) begin errors++;
      $display("FAIL wrap_owner2 got g=%b d=%h want 100 30", grant, dac_out); end
    period_done = 3'b100;
    tick();
    period_done = 3'b000;
    checks++; if (grant !== 3'b000 || busy !== 1'b1) begin errors++;
      $display("FAIL wrap_drain2 got g=%b b=%b want 000 1", grant, busy); end
    tick();
    checks++; if (grant !== 3'b001) begin errors++;
      $display("FAIL wrap_to0 got %b want 001", grant); end
    period_done = 3'b110;
    tick();
    period_done = 3'b000;
    checks++; if (grant !== 3'b001 || busy !== 1'b1) begin errors++;
      $display("FAIL nonowner_ignored got g=%b b=%b want 001 1", grant, busy); end
  endtask

  task automatic test_drop_request();
    req = 3'b000;
    tick();
    checks++; if (grant !== 3'b001) begin errors++;
      $display("FAIL drop_hold1 got %b want 001", grant); end
    tick();
    checks++; if (grant !== 3'b001 || busy !== 1'b1) begin errors++;
      $display("FAIL drop_hold2 got g=%b b=%b want 001 1", grant, busy); end
    period_done = 3'b001;
    tick();
    period_done = 3'b000;
    checks++; if (grant !== 3'b000 || busy !== 1'b1 || dac_out !== 8'h00) begin errors++;
      $display("FAIL drop_drain got g=%b b=%b d=%h want 000 1 00", grant, busy, dac_out); end
    tick();
    checks++; if (grant !== 3'b000 || busy !== 1'b0 || src_enable !== 3'b000) begin errors++;
      $display("FAIL drop_idle got g=%b b=%b e=%b want 000 0 000", grant, busy, src_enable); end
  endtask

  task automatic test_reset_mid_run();
    req = 3'b100;
    tick();
    checks++; if (grant !== 3'b100) begin errors++;
      $display("FAIL mid_grant2 got %b want 100", grant); end
    tick();
    reset = 1'b0;
    tick();
    checks++; if ({grant, src_enable, dac_out, busy, fault} !== 16'h0) begin errors++;
      $display("FAIL mid_reset got g=%b e=%b d=%h b=%b f=%b want all 0", grant, src_enable, dac_out, busy, fault); end
    req = 3'b111; reset = 1'b1;
    tick();
    checks++; if (grant !== 3'b001) begin errors++;
      $display("FAIL mid_after_release got %b want 001", grant); end
  endtask

  task automatic test_timeout();
    reset = 1'b0; req = 3'b001; period_done = 3'b000;
    tick();
    reset = 1'b1;
    tick();
    checks++; if (grant !== 3'b001 || fault !== 1'b0) begin errors++;
      $display("FAIL to_entry got g=%b f=%b want 001 0", grant, fault); end
`ifdef WAVE_SCHED_TIMEOUT_EN
    for (int k = 0; k < 15; k++) tick();
    checks++; if (grant !== 3'b001 || fault !== 1'b0) begin errors++;
      $display("FAIL to_before got g=%b f=%b want 001 0", grant, fault); end
    tick();
    checks++; if (grant !== 3'b000 || fault !== 1'b1 || busy !== 1'b1) begin errors++;
      $display("FAIL to_drain got g=%b f=%b b=%b want 000 1 1", grant, fault, busy); end
    tick();
    checks++; if (grant !== 3'b001 || fault !== 1'b1) begin errors++;
      $display("FAIL to_sticky got g=%b f=%b want 001 1", grant, fault); end
    reset = 1'b0;
    tick();
    checks++; if (fault !== 1'b0) begin errors++;
      $display("FAIL to_clear got %b want 0", fault); end
    reset = 1'b1;
`else
    for (int k = 0; k < 40; k++) tick();
    checks++; if (grant !== 3'b001 || fault !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL no_timeout got g=%b f=%b b=%b want 001 0 1", grant, fault, busy); end
`endif
  endtask

  initial begin
    test_reset();
    test_sole_requester();
    test_rotate_and_wrap();
    test_drop_request();
    test_reset_mid_run();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
